alu_result_fifo: RTL

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo_if.sv | 23 ++
 rtl/alu_result_fifo.sv | 83 ++++++++
 2 files changed

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer bundle for the ALU result FIFO: a push channel (in_*) and a pop channel (out_*).
interface alu_result_fifo_if #(
  parameter int M = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [M-1:0] in_res;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_sel;
  logic [M-1:0] out_res;

  modport master (
    output in_valid, in_sel, in_res, out_ready,
    input  in_ready, out_valid, out_sel, out_res
  );

  modport slave (
    input  in_valid, in_sel, in_res, out_ready,
    output in_ready, out_valid, out_sel, out_res
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO of {opcode, result} pairs with a saturating drop counter
// and a running sum of popped results.
module alu_result_fifo #(
  parameter int N     = 8,
  parameter int M     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_result_fifo_if.slave           bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_cnt,
  output logic [M-1:0]               acc_sum
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (N < 1 || M < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("alu_result_fifo: illegal parameters");
  end

  logic [M+2:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_drop;
  logic [M-1:0]  r_acc;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Handshake: a transfer happens on an edge where valid and ready are both 1. in_ready and
  // out_valid come from registered count only, so a full FIFO refuses a push even while popping.
  assign w_in_ready  = (r_count != FULL_CNT);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_drop      = bus.in_valid & ~w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sel   = r_mem[r_rptr][M+2:M];
  assign bus.out_res   = r_mem[r_rptr][M-1:0];
  assign count         = r_count;
  assign drop_cnt      = r_drop;
  assign acc_sum       = r_acc;

  // Storage has no reset; out_* are only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wptr] <= {bus.in_sel, bus.in_res};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_acc   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_acc  <= r_acc + bus.out_res;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW + 1)'(1);
      end
      if (w_drop && r_drop != 8'hFF) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end
endmodule
